pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter Width, default 32, payload bit width (>=1).
REQ-002 SHALL have parameter Depth, default 2, number of register stages (>=1).
REQ-003 SHALL have parameter ClearData, default 0; when 1, flush also zeroes stage data.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous clear of all stages.
REQ-007 SHALL have port valid_i  input  1  upstream item present.
REQ-008 SHALL have port ready_o  output  1  chain accepts an item this cycle.
REQ-009 SHALL have port data_i  input  Width  upstream payload.
REQ-010 SHALL have port valid_o  output  1  item present at chain output.
REQ-011 SHALL have port ready_i  input  1  downstream accepts this cycle.
REQ-012 SHALL have port data_o  output  Width  payload of last stage.
REQ-013 SHALL have port count_o  output  $clog2(Depth+1)  number of occupied stages.

Function
REQ-014 SHALL hold per stage k (0..Depth-1) a valid bit v[k] and data register d[k]; stage 0 faces input, stage Depth-1 drives data_o.
REQ-015 SHALL compute adv[Depth-1] = !v[Depth-1] || ready_i, and adv[k] = !v[k] || adv[k+1] for k<Depth-1 (combinational, bubble-collapsing).
REQ-016 SHALL drive ready_o = adv[0] && !flush_i, valid_o = v[Depth-1] && !flush_i, data_o = d[Depth-1].
REQ-017 SHALL define input transfer as valid_i && ready_o, output transfer as valid_o && ready_i, both at the rising edge.
REQ-018 SHALL, when !flush_i and adv[k], load v[k] from source valid (valid_i for k=0, v[k-1] otherwise) and load d[k] from source data only if source valid; d[k] otherwise holds.
REQ-019 SHALL, when !flush_i and !adv[k], hold v[k] and d[k] unchanged (stall).
REQ-020 SHALL, when flush_i is high at an edge, clear every v[k]; d[k] zeroed if ClearData=1, else held; no transfer occurs that cycle in either direction.
REQ-021 SHALL sustain one transfer per cycle in and out when ready_i is continuously high.
REQ-022 SHALL present an item accepted at edge n on data_o with valid_o high after edge n+Depth-1, absent downstream stall.
REQ-023 SHALL fill bubbles: an item advances into an empty stage even while later stages stall.
REQ-024 SHALL never drop, duplicate or reorder items except via flush_i or reset.
REQ-025 SHALL drive count_o as the population count of v[], combinational from registers, range 0..Depth.
REQ-026 SHALL, when full (count_o=Depth) and ready_i=1, keep ready_o=1 so a simultaneous input and output transfer leaves count_o unchanged.
REQ-027 SHALL not gate data_i or data_o on valid; data_o is don't-care to consumers when valid_o=0.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously force all v[k]=0 and all d[k]=0, giving valid_o=0, data_o=0, count_o=0, ready_o=1 (when flush_i=0).
REQ-029 SHALL, when rst_ni is asserted mid-stream, discard all in-flight items immediately and resume accepting on the first edge after release.
REQ-030 SHALL give reset priority over flush_i and over all transfers.

Verification
REQ-031 SHALL cover streaming: Depth=2, valid_i=1 with data 1,2,3,... each cycle, ready_i=1 -> data_o=1 after the 2nd edge, then +1 every cycle, count_o=2 steady.
REQ-032 SHALL cover backpressure: Depth=3, push A,B,C with ready_i=0 -> count_o=3, ready_o=0; raise ready_i for 3 cycles -> A,B,C out in order, count_o back to 0.
REQ-033 SHALL cover bubble collapse: Depth=3, push A only, ready_i=0 -> A reaches stage 2 after 3 edges, count_o=1, ready_o stays 1.
REQ-034 SHALL cover simultaneous full in/out: Depth=2 full with X,Y, ready_i=1, valid_i=1 data Z -> X leaves, Z accepted, count_o stays 2.
REQ-035 SHALL cover flush: Depth=2 holding 0xAA,0xBB, flush_i=1 with valid_i=1 -> ready_o=0, valid_o=0 that cycle, count_o=0 next; with ClearData=1 data_o=0, else data_o=0xBB.
REQ-036 SHALL cover async reset: rst_ni dropped between edges with count_o=2 -> valid_o=0, data_o=0, count_o=0 before the next edge.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Purpose:
//   A chain of Depth valid/ready register stages carrying a Width-bit payload.
//   Bubbles collapse: an item moves into an empty stage even while stages
//   further downstream are stalled. The chain can therefore hold Depth items
//   and still sustain one transfer per cycle in each direction. A synchronous
//   flush empties the chain. When ClearData=1 the flush also zeroes the
//   payload registers.
//
// Parameters:
//   Width     payload width in bits (>= 1)
//   Depth     number of register stages (>= 1)
//   ClearData 1: flush also zeroes the stage data; 0: data is held on flush
//
// Ports:
//   clk_i    in   1                 clock; all state changes on the rising edge
//   rst_ni   in   1                 asynchronous active-low reset
//   flush_i  in   1                 synchronous clear of every stage
//   valid_i  in   1                 an upstream item is present
//   ready_o  out  1                 the chain accepts an item this cycle
//   data_i   in   Width             upstream payload
//   valid_o  out  1                 an item is present at the chain output
//   ready_i  in   1                 downstream accepts this cycle
//   data_o   out  Width             payload of the last stage
//   count_o  out  clog2(Depth+1)    number of occupied stages
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int Width     = 32,
    parameter int Depth     = 2,
    parameter bit ClearData = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [Width-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int CntW = $clog2(Depth + 1);

    logic [Depth-1:0] r_valid;
    logic [Width-1:0] r_data [Depth];

    logic [Depth-1:0] w_adv;
    logic [Depth-1:0] w_src_valid;
    logic [Width-1:0] w_src_data [Depth];
    logic [CntW-1:0]  w_count;

    // Stage k may advance when it or any later stage is empty, or when the
    // output is being drained. This is the closed form of the recurrence
    // adv[k] = !v[k] || adv[k+1]. Writing it this way avoids a combinational
    // chain through a single vector.
    for (genvar k = 0; k < Depth; k++) begin : g_adv
        assign w_adv[k] = ready_i || !(&r_valid[Depth-1:k]);
    end

    // Source of each stage: the chain input for stage 0, and the previous
    // stage for every other stage.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a value
        // on all paths first. Otherwise a latch is inferred.
        w_src_valid    = '0;
        w_src_data[0]  = data_i;
        w_src_valid[0] = valid_i;
        for (int k = 1; k < Depth; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the payload registers are reset as well as the valid bits,
            // so data_o reads zero out of reset rather than stale contents.
            for (int k = 0; k < Depth; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < Depth; k++) begin
                r_valid[k] <= 1'b0;
                if (ClearData) begin
                    r_data[k] <= '0;
                end
            end
        end else begin
            // NOTE: state uses non-blocking assignments, so each stage sees the
            // pre-edge value of its neighbour regardless of loop order.
            for (int k = 0; k < Depth; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    // An empty source leaves the payload alone. This avoids
                    // needless toggling of the data registers.
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_src_data[k];
                    end
                end
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < Depth; k++) begin
            w_count = w_count + CntW'(r_valid[k]);
        end
    end

    assign ready_o = w_adv[0] && !flush_i;
    assign valid_o = r_valid[Depth-1] && !flush_i;
    assign data_o  = r_data[Depth-1];
    assign count_o = w_count;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Three chains receive identical stimulus:
//   inst0 Depth=2 ClearData=0, inst1 Depth=2 ClearData=1, inst2 Depth=3 ClearData=0.
// A reference model tracks each chain as an ordered list of items. Each item
// carries its stage position. Every cycle the oldest item advances one stage,
// or leaves when it is at the output and downstream is ready. Each younger
// item then advances one stage but may not catch up with the item ahead.
// Directed scenarios with literal expectations come first, then random
// traffic with occasional flushes and asynchronous reset pulses.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int W  = 8;
    localparam int NI = 3;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic         flush   = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [W-1:0] data_i  = '0;

    logic [NI-1:0] valid_o;
    logic [NI-1:0] ready_o;
    logic [W-1:0]  data_o  [NI];
    logic [1:0]    count_o [NI];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.Width(W), .Depth(2), .ClearData(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ready_o[0]), .data_i(data_i),
        .valid_o(valid_o[0]), .ready_i(ready_i), .data_o(data_o[0]),
        .count_o(count_o[0])
    );

    pipe_stage_chain #(.Width(W), .Depth(2), .ClearData(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ready_o[1]), .data_i(data_i),
        .valid_o(valid_o[1]), .ready_i(ready_i), .data_o(data_o[1]),
        .count_o(count_o[1])
    );

    pipe_stage_chain #(.Width(W), .Depth(3), .ClearData(1'b0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ready_o[2]), .data_i(data_i),
        .valid_o(valid_o[2]), .ready_i(ready_i), .data_o(data_o[2]),
        .count_o(count_o[2])
    );

    // ---------------- reference model ----------------
    int     m_size [NI];
    int     m_pos  [NI][8];
    bit [W-1:0] m_dat [NI][8];
    bit [W-1:0] m_last [NI];   // payload last delivered into the output stage

    function automatic int dep_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic bit clr_of(input int i);
        return (i == 1);
    endfunction

    // The chain can take an item whenever a slot is free or the output drains.
    function automatic bit m_ready(input int i);
        return (m_size[i] < dep_of(i) || ready_i) && !flush;
    endfunction

    function automatic bit m_valid(input int i);
        return m_size[i] > 0 && m_pos[i][0] == dep_of(i) - 1 && !flush;
    endfunction

    task automatic m_clear(input int i, input bit data_too);
        m_size[i] = 0;
        if (data_too) m_last[i] = '0;
    endtask

    task automatic m_step(input int i);
        int d;
        int lim;
        int n;
        int np;
        bit acc;
        d   = dep_of(i);
        acc = valid_i && m_ready(i);
        if (flush) begin
            m_clear(i, clr_of(i));
            return;
        end
        lim = d;
        n   = 0;
        for (int j = 0; j < m_size[i]; j++) begin
            if (j == 0 && m_pos[i][0] == d - 1 && ready_i) continue;
            np = m_pos[i][j] + 1;
            if (np > lim - 1) np = lim - 1;
            m_pos[i][n] = np;
            m_dat[i][n] = m_dat[i][j];
            lim = np;
            n++;
        end
        if (acc) begin
            m_pos[i][n] = 0;
            m_dat[i][n] = data_i;
            n++;
        end
        m_size[i] = n;
        if (n > 0 && m_pos[i][0] == d - 1) m_last[i] = m_dat[i][0];
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) m_clear(i, 1'b1);
            else        m_step(i);
        end
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < NI; i++) m_clear(i, 1'b1);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("inst%0d valid_o", i), 32'(valid_o[i]), 32'(m_valid(i)));
                check($sformatf("inst%0d ready_o", i), 32'(ready_o[i]), 32'(m_ready(i)));
                check($sformatf("inst%0d count_o", i), 32'(count_o[i]), 32'(m_size[i]));
                check($sformatf("inst%0d data_o", i),  32'(data_o[i]),  32'(m_last[i]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        #2;
        cmp_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset inst%0d valid_o", i), 32'(valid_o[i]), 32'd0);
            check($sformatf("reset inst%0d data_o", i),  32'(data_o[i]),  32'd0);
            check($sformatf("reset inst%0d count_o", i), 32'(count_o[i]), 32'd0);
            check($sformatf("reset inst%0d ready_o", i), 32'(ready_o[i]), 32'd1);
        end
        tick;
        rst_n = 1'b1;

        // Streaming 1,2,3,... with downstream always ready.
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'd1;
        tick;
        data_i = 8'd2;
        tick;
        check("stream d2 data_o after edge 2", 32'(data_o[0]), 32'd1);
        check("stream d2 valid_o after edge 2", 32'(valid_o[0]), 32'd1);
        check("stream d2 count_o", 32'(count_o[0]), 32'd2);
        data_i = 8'd3;
        tick;
        check("stream d2 data_o after edge 3", 32'(data_o[0]), 32'd2);
        check("stream d3 data_o after edge 3", 32'(data_o[2]), 32'd1);
        for (int v = 4; v <= 8; v++) begin
            data_i = 8'(v);
            tick;
            check("stream d2 data_o increments", 32'(data_o[0]), 32'(v - 1));
            check("stream d2 count_o steady", 32'(count_o[0]), 32'd2);
        end
        valid_i = 1'b0;
        repeat (4) tick;

        // Backpressure: fill the Depth=3 chain, then drain it in order.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hA1;
        tick;
        data_i = 8'hB2;
        tick;
        data_i = 8'hC3;
        tick;
        valid_i = 1'b0;
        #1;
        check("backpressure d3 count_o full", 32'(count_o[2]), 32'd3);
        check("backpressure d3 ready_o", 32'(ready_o[2]), 32'd0);
        check("backpressure d3 head", 32'(data_o[2]), 32'hA1);
        ready_i = 1'b1;
        tick;
        check("drain d3 second", 32'(data_o[2]), 32'hB2);
        tick;
        check("drain d3 third", 32'(data_o[2]), 32'hC3);
        tick;
        check("drain d3 count_o empty", 32'(count_o[2]), 32'd0);
        check("drain d3 valid_o", 32'(valid_o[2]), 32'd0);

        // Bubble collapse: a single item travels to the end of a stalled chain.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h5A;
        tick;
        valid_i = 1'b0;
        #1;
        check("bubble d3 not yet out", 32'(valid_o[2]), 32'd0);
        tick;
        tick;
        check("bubble d3 valid_o", 32'(valid_o[2]), 32'd1);
        check("bubble d3 data_o", 32'(data_o[2]), 32'h5A);
        check("bubble d3 count_o", 32'(count_o[2]), 32'd1);
        check("bubble d3 ready_o", 32'(ready_o[2]), 32'd1);
        ready_i = 1'b1;
        repeat (3) tick;

        // Full chain with a simultaneous input and output transfer.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h11;
        tick;
        data_i = 8'h22;
        tick;
        data_i  = 8'h33;
        ready_i = 1'b1;
        #1;
        check("full io d2 ready_o", 32'(ready_o[0]), 32'd1);
        check("full io d2 head", 32'(data_o[0]), 32'h11);
        tick;
        check("full io d2 count_o kept", 32'(count_o[0]), 32'd2);
        check("full io d2 next", 32'(data_o[0]), 32'h22);
        valid_i = 1'b0;
        repeat (4) tick;

        // Flush with an item offered at the input.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hBB;
        tick;
        data_i = 8'hAA;
        tick;
        data_i  = 8'hCC;
        flush   = 1'b1;
        ready_i = 1'b1;
        #1;
        check("flush d2 ready_o low", 32'(ready_o[0]), 32'd0);
        check("flush d2 valid_o low", 32'(valid_o[0]), 32'd0);
        tick;
        flush   = 1'b0;
        valid_i = 1'b0;
        #1;
        check("flush d2 count_o", 32'(count_o[0]), 32'd0);
        check("flush d2 data held", 32'(data_o[0]), 32'hBB);
        check("flush clear count_o", 32'(count_o[1]), 32'd0);
        check("flush clear data zero", 32'(data_o[1]), 32'd0);

        // Asynchronous reset between edges while the chain holds two items.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h77;
        tick;
        data_i = 8'h78;
        tick;
        valid_i = 1'b0;
        check("pre-reset d2 count_o", 32'(count_o[0]), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset valid_o", 32'(valid_o[0]), 32'd0);
        check("async reset data_o", 32'(data_o[0]), 32'd0);
        check("async reset count_o", 32'(count_o[0]), 32'd0);
        #1;
        rst_n   = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h99;
        tick;
        valid_i = 1'b0;
        check("resume after reset count_o", 32'(count_o[0]), 32'd1);

        // Random traffic with rare flushes and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 6);
            data_i  = 8'($urandom);
            flush   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick;
        end
        flush   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
